if_exec_controller: RTL and testbench
=====================================

Name: if_exec_controller

Overview:
- Sequences the instruction-fetch stage for the debug unit: assembles program bytes into 32-bit instruction words and writes them into IF instruction memory.
- Issues the start pulse, then gates the pipeline enable in continuous (RUN) or single-step (STEP) mode until the pipeline reports end of program.
- Sits between the UART debug front-end and the IF stage's i_write_mem / i_instruction / i_start / i_enable inputs.

Parameters:
- WORD_BITS, 32, instruction width; must be a multiple of 8.
- HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates a program load.
- CNT_BITS, 32, width of the cycle and load counters.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous reset, active-low.
- i_cmd_valid  in  1  command strobe, 1 cycle.
- i_cmd  in  3  1=LOAD, 2=RUN, 3=STEP, 4=ABORT; other values are ignored.
- i_byte_valid  in  1  program byte strobe.
- i_byte  in  8  program byte, MSB-first within each word.
- i_full_mem  in  1  IF instruction memory full.
- i_end_program  in  1  pipeline reports the halt instruction has retired.
- o_write_mem  out  1  1-cycle write pulse to IF.
- o_instruction  out  WORD_BITS  assembled word; valid while o_write_mem=1.
- o_start  out  1  1-cycle pulse that resets the PC and starts the program.
- o_enable  out  1  pipeline clock enable.
- o_state  out  3  current state encoding: IDLE=0, LOAD=1, READY=2, RUN=3, STEP=4, DONE=5.
- o_load_count  out  CNT_BITS  words written in the current load.
- o_cycle_count  out  CNT_BITS  enabled cycles since the last o_start; saturates at all-ones.
- o_error  out  1  sticky overflow flag; cleared by the next accepted LOAD.

Behaviour:
- Reset (i_reset=0, async): state=IDLE; all outputs 0; byte index cleared. Reset mid-load discards the partial word.
- All outputs are registered. Commands are evaluated only when i_cmd_valid=1; a command that is not legal in the current state is ignored with no side effects.
- ABORT, any state: next cycle state=IDLE, o_enable=0, partial word discarded. Counters and o_error are held.
- IDLE/READY/DONE + LOAD: state=LOAD; o_load_count=0; o_error=0; byte index=0.
- LOAD:
  - Each i_byte_valid shifts i_byte in at the LSB side (first byte lands in bits 31:24). Bytes are ignored in every other state.
  - On the 4th byte, the cycle after it is accepted: o_write_mem=1 for 1 cycle, o_instruction=word, o_load_count+1.
  - If i_full_mem=1 when the 4th byte arrives: no write, o_error=1, state=IDLE.
  - If the word equals HALT_WORD: it is written, then state=READY on the same edge as the write pulse.
- READY/DONE + RUN: o_start=1 for 1 cycle, o_cycle_count=0, state=RUN. o_enable=1 starting with the o_start cycle.
- RUN:
  - o_enable=1 each cycle; o_cycle_count increments each enabled cycle.
  - i_end_program=1 → next cycle o_enable=0, state=DONE. The cycle that samples i_end_program is counted.
- READY/DONE + STEP: o_start=1 and o_enable=1 for exactly 1 cycle, o_cycle_count=1, state=STEP.
- STEP:
  - o_enable=0 except for exactly 1 cycle after each STEP command; o_cycle_count+1 per step.
  - RUN while in STEP switches to RUN without an o_start pulse.
  - i_end_program=1 → state=DONE.
- Simultaneous events:
  - i_cmd_valid and i_byte_valid in the same cycle: the command wins and the byte is dropped.
  - i_end_program in the same cycle as a STEP command: DONE wins and no step is issued.
- A counter at all-ones holds its value; it never wraps.

Test Plan:
- Reset: hold i_reset=0 for 5 cycles, release → o_state=0, all outputs 0. Assert i_reset=0 mid-load after 2 bytes → IDLE; a fresh LOAD writes the next word from byte 0.
- Load: LOAD, then bytes 12 34 56 78, then FF FF FF FF → two o_write_mem pulses with 32'h12345678 and 32'hFFFFFFFF; o_load_count=2; o_state=2.
- Run: RUN, i_end_program driven 7 cycles after o_start → o_start high 1 cycle; o_enable high 8 cycles; o_cycle_count=8; o_state=5.
- Step: from READY issue STEP three times, 5 cycles apart → exactly 3 single-cycle o_enable pulses; o_start only with the first; o_cycle_count=3. A RUN command then continues with no o_start.
- Overflow: i_full_mem=1 while the 4th byte of word 32'hDEADBEEF arrives → no write, o_error=1, o_state=0. A following LOAD clears o_error.
- Abort and illegal commands: ABORT during RUN → o_enable=0 next cycle, o_state=0, o_cycle_count held. cmd=7 in any state, or RUN in IDLE → no state or output change.

Source files
------------

// File: rtl/if_exec_controller.sv
// ---------------------------------------------------------------------------
// if_exec_controller
//
// Purpose:
//   Instruction-fetch sequencer for the debug unit. In LOAD it assembles
//   program bytes (MSB first) into WORD_BITS-wide instruction words and
//   writes each one into the IF instruction memory. A HALT_WORD ends the
//   load. It then issues the start pulse and gates the pipeline enable,
//   either continuously (RUN) or one cycle per command (STEP), until the
//   pipeline reports end of program.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous reset, active-low
//   i_cmd_valid    command strobe (1 cycle)
//   i_cmd          1=LOAD 2=RUN 3=STEP 4=ABORT, other codes ignored
//   i_byte_valid   program byte strobe
//   i_byte         program byte, MSB first within each word
//   i_full_mem     IF instruction memory is full
//   i_end_program  halt instruction has retired in the pipeline
//   o_write_mem    1-cycle write pulse to IF
//   o_instruction  assembled word, valid while o_write_mem=1
//   o_start        1-cycle pulse: reset PC and start the program
//   o_enable       pipeline clock enable
//   o_state        IDLE=0 LOAD=1 READY=2 RUN=3 STEP=4 DONE=5
//   o_load_count   words written in the current load (saturating)
//   o_cycle_count  enabled cycles since last o_start (saturating)
//   o_error        sticky memory-overflow flag, cleared by accepted LOAD
// ---------------------------------------------------------------------------
module if_exec_controller #(
    parameter int                   WORD_BITS = 32,
    parameter logic [WORD_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int                   CNT_BITS  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [2:0]           i_cmd,
    input  logic                 i_byte_valid,
    input  logic [7:0]           i_byte,
    input  logic                 i_full_mem,
    input  logic                 i_end_program,
    output logic                 o_write_mem,
    output logic [WORD_BITS-1:0] o_instruction,
    output logic                 o_start,
    output logic                 o_enable,
    output logic [2:0]           o_state,
    output logic [CNT_BITS-1:0]  o_load_count,
    output logic [CNT_BITS-1:0]  o_cycle_count,
    output logic                 o_error
);

    localparam int NB    = WORD_BITS / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] CMD_RUN   = 3'd2;
    localparam logic [2:0] CMD_STEP  = 3'd3;
    localparam logic [2:0] CMD_ABORT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_STEP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    state_t                r_state;
    state_t                w_state_nx;
    logic [IDX_W-1:0]      r_idx;
    logic [WORD_BITS-1:0]  r_shift;

    logic                  r_write_mem;
    logic [WORD_BITS-1:0]  r_instruction;
    logic                  r_start;
    logic                  r_enable;
    logic [CNT_BITS-1:0]   r_load_count;
    logic [CNT_BITS-1:0]   r_cycle_count;
    logic                  r_error;

    logic                  w_write_nx;
    logic [WORD_BITS-1:0]  w_instr_nx;
    logic                  w_start_nx;
    logic                  w_enable_nx;
    logic [CNT_BITS-1:0]   w_load_cnt_nx;
    logic [CNT_BITS-1:0]   w_cycle_cnt_nx;
    logic                  w_error_nx;
    logic [IDX_W-1:0]      w_idx_nx;

    logic                  w_cmd_load;
    logic                  w_cmd_run;
    logic                  w_cmd_step;
    logic                  w_cmd_abort;
    logic                  w_byte_take;
    logic                  w_word_last;
    logic [WORD_BITS+7:0]  w_shift_ext;
    logic [WORD_BITS-1:0]  w_word;

    assign w_cmd_load  = i_cmd_valid && (i_cmd == CMD_LOAD);
    assign w_cmd_run   = i_cmd_valid && (i_cmd == CMD_RUN);
    assign w_cmd_step  = i_cmd_valid && (i_cmd == CMD_STEP);
    assign w_cmd_abort = i_cmd_valid && (i_cmd == CMD_ABORT);

    // Any command strobe, legal or not, takes priority over a byte in the
    // same cycle; the byte is simply dropped.
    assign w_byte_take = (r_state == S_LOAD) && i_byte_valid && !i_cmd_valid;
    assign w_word_last = w_byte_take && (r_idx == IDX_LAST);

    // New byte enters at the LSB, so the first byte of a word ends up on top.
    assign w_shift_ext = {r_shift, i_byte};
    assign w_word      = w_shift_ext[WORD_BITS-1:0];

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        if (w_cmd_abort) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_load) w_state_nx = S_LOAD;
                end
                S_LOAD: begin
                    if (w_word_last) begin
                        if (i_full_mem)               w_state_nx = S_IDLE;
                        else if (w_word == HALT_WORD) w_state_nx = S_READY;
                    end
                end
                S_READY, S_DONE: begin
                    if (w_cmd_load)      w_state_nx = S_LOAD;
                    else if (w_cmd_run)  w_state_nx = S_RUN;
                    else if (w_cmd_step) w_state_nx = S_STEP;
                end
                S_RUN: begin
                    if (i_end_program) w_state_nx = S_DONE;
                end
                S_STEP: begin
                    // End of program beats a simultaneous STEP or RUN.
                    if (i_end_program)  w_state_nx = S_DONE;
                    else if (w_cmd_run) w_state_nx = S_RUN;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_write_nx     = 1'b0;
        w_instr_nx     = r_instruction;
        w_start_nx     = 1'b0;
        w_enable_nx    = 1'b0;
        w_load_cnt_nx  = r_load_count;
        w_cycle_cnt_nx = r_cycle_count;
        w_error_nx     = r_error;
        w_idx_nx       = r_idx;

        if (w_cmd_abort) begin
            // Counters and error are kept for inspection; the partial word is lost.
            w_idx_nx = '0;
        end else begin
            case (r_state)
                S_IDLE, S_READY, S_DONE: begin
                    if (w_cmd_load) begin
                        w_load_cnt_nx = '0;
                        w_error_nx    = 1'b0;
                        w_idx_nx      = '0;
                    end else if (r_state != S_IDLE && w_cmd_run) begin
                        w_start_nx     = 1'b1;
                        w_enable_nx    = 1'b1;
                        w_cycle_cnt_nx = '0;
                    end else if (r_state != S_IDLE && w_cmd_step) begin
                        // The first step is counted when it is issued.
                        w_start_nx     = 1'b1;
                        w_enable_nx    = 1'b1;
                        w_cycle_cnt_nx = CNT_ONE;
                    end
                end
                S_LOAD: begin
                    if (w_byte_take) begin
                        w_idx_nx = w_word_last ? '0 : (r_idx + IDX_ONE);
                        if (w_word_last) begin
                            if (i_full_mem) begin
                                w_error_nx = 1'b1;
                            end else begin
                                w_write_nx    = 1'b1;
                                w_instr_nx    = w_word;
                                w_load_cnt_nx = sat_inc(r_load_count);
                            end
                        end
                    end
                end
                S_RUN: begin
                    // Enable is always high in RUN, including the cycle that
                    // samples end of program, so every edge here counts.
                    w_cycle_cnt_nx = sat_inc(r_cycle_count);
                    w_enable_nx    = !i_end_program;
                end
                S_STEP: begin
                    if (!i_end_program) begin
                        if (w_cmd_run) begin
                            w_enable_nx = 1'b1;
                        end else if (w_cmd_step) begin
                            w_enable_nx    = 1'b1;
                            w_cycle_cnt_nx = sat_inc(r_cycle_count);
                        end
                    end
                end
                default: begin
                    w_idx_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_write_mem   <= 1'b0;
            r_instruction <= '0;
            r_start       <= 1'b0;
            r_enable      <= 1'b0;
            r_load_count  <= '0;
            r_cycle_count <= '0;
            r_error       <= 1'b0;
            r_idx         <= '0;
        end else begin
            r_write_mem   <= w_write_nx;
            r_instruction <= w_instr_nx;
            r_start       <= w_start_nx;
            r_enable      <= w_enable_nx;
            r_load_count  <= w_load_cnt_nx;
            r_cycle_count <= w_cycle_cnt_nx;
            r_error       <= w_error_nx;
            r_idx         <= w_idx_nx;
        end
    end

    // Byte assembly register; stale contents are harmless because the
    // byte index restarts at zero and a full word overwrites every byte.
    always_ff @(posedge i_clk) begin
        if (w_byte_take) begin
            r_shift <= w_word;
        end
    end

    assign o_write_mem   = r_write_mem;
    assign o_instruction = r_instruction;
    assign o_start       = r_start;
    assign o_enable      = r_enable;
    assign o_state       = r_state;
    assign o_load_count  = r_load_count;
    assign o_cycle_count = r_cycle_count;
    assign o_error       = r_error;

endmodule

// File: tb/tb_if_exec_controller.sv
module tb_if_exec_controller;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic [2:0]  i_cmd = 3'd0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = 8'd0;
    logic        i_full_mem = 1'b0;
    logic        i_end_program = 1'b0;
    logic        o_write_mem;
    logic [31:0] o_instruction;
    logic        o_start;
    logic        o_enable;
    logic [2:0]  o_state;
    logic [31:0] o_load_count;
    logic [31:0] o_cycle_count;
    logic        o_error;

    int n_assert = 0;
    int n_fail   = 0;

    if_exec_controller #(
        .WORD_BITS (32),
        .HALT_WORD (32'hFFFF_FFFF),
        .CNT_BITS  (32)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .i_byte_valid  (i_byte_valid),
        .i_byte        (i_byte),
        .i_full_mem    (i_full_mem),
        .i_end_program (i_end_program),
        .o_write_mem   (o_write_mem),
        .o_instruction (o_instruction),
        .o_start       (o_start),
        .o_enable      (o_enable),
        .o_state       (o_state),
        .o_load_count  (o_load_count),
        .o_cycle_count (o_cycle_count),
        .o_error       (o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] c);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd       = 3'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_byte_valid = 1'b1;
        i_byte       = b;
        tick();
        i_byte_valid = 1'b0;
        i_byte       = 8'd0;
    endtask

    initial begin
        // Reset held for 5 cycles
        #1 i_reset = 1'b0;
        repeat (5) tick();
        chk3("state_in_reset", o_state, 3'd0);
        i_reset = 1'b1;
        tick();
        chk3 ("rst_state",  o_state, 3'd0);
        chk1 ("rst_write",  o_write_mem, 1'b0);
        chk32("rst_instr",  o_instruction, 32'h0);
        chk1 ("rst_start",  o_start, 1'b0);
        chk1 ("rst_enable", o_enable, 1'b0);
        chk32("rst_lcnt",   o_load_count, 32'h0);
        chk32("rst_ccnt",   o_cycle_count, 32'h0);
        chk1 ("rst_error",  o_error, 1'b0);

        // Reset in the middle of a word
        send_cmd(3'd1);
        chk3("load_state", o_state, 3'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 i_reset = 1'b0;
        #1 chk3("async_rst_state", o_state, 3'd0);
        tick();
        i_reset = 1'b1;
        tick();

        // Program load: one word then the halt word
        send_cmd(3'd1);
        chk3("reload_state", o_state, 3'd1);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        chk1("no_write_early", o_write_mem, 1'b0);
        send_byte(8'h78);
        chk1 ("w1_write", o_write_mem, 1'b1);
        chk32("w1_instr", o_instruction, 32'h12345678);
        chk32("w1_lcnt",  o_load_count, 32'd1);
        chk3 ("w1_state", o_state, 3'd1);
        tick();
        chk1("w1_pulse_end", o_write_mem, 1'b0);
        repeat (4) send_byte(8'hFF);
        chk1 ("w2_write", o_write_mem, 1'b1);
        chk32("w2_instr", o_instruction, 32'hFFFFFFFF);
        chk32("w2_lcnt",  o_load_count, 32'd2);
        chk3 ("w2_state", o_state, 3'd2);

        // Continuous run, end of program 7 cycles after start
        send_cmd(3'd2);
        chk1 ("run_start",  o_start, 1'b1);
        chk1 ("run_enable", o_enable, 1'b1);
        chk32("run_ccnt0",  o_cycle_count, 32'd0);
        chk3 ("run_state",  o_state, 3'd3);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk1 ("run_start_low", o_start, 1'b0);
            chk1 ("run_enable_hi", o_enable, 1'b1);
            chk32("run_ccnt",      o_cycle_count, 32'(k));
        end
        i_end_program = 1'b1;
        tick();
        i_end_program = 1'b0;
        chk1 ("end_enable", o_enable, 1'b0);
        chk32("end_ccnt",   o_cycle_count, 32'd8);
        chk3 ("end_state",  o_state, 3'd5);

        // Reload from DONE, then single-step three times
        send_cmd(3'd1);
        chk3("done_load_state", o_state, 3'd1);
        repeat (4) send_byte(8'hFF);
        chk3 ("halt_only_state", o_state, 3'd2);
        chk32("halt_only_lcnt",  o_load_count, 32'd1);
        for (int s = 1; s <= 3; s++) begin
            send_cmd(3'd3);
            chk1 ("step_enable", o_enable, 1'b1);
            chk1 ("step_start",  o_start, (s == 1));
            chk32("step_ccnt",   o_cycle_count, 32'(s));
            chk3 ("step_state",  o_state, 3'd4);
            for (int w = 0; w < 4; w++) begin
                tick();
                chk1("step_gap_enable", o_enable, 1'b0);
                chk1("step_gap_start",  o_start, 1'b0);
            end
        end
        chk32("step_total", o_cycle_count, 32'd3);

        // RUN from STEP: no start pulse
        send_cmd(3'd2);
        chk3 ("s2r_state",  o_state, 3'd3);
        chk1 ("s2r_start",  o_start, 1'b0);
        chk1 ("s2r_enable", o_enable, 1'b1);
        chk32("s2r_ccnt",   o_cycle_count, 32'd3);
        tick();
        chk32("s2r_ccnt_inc", o_cycle_count, 32'd4);

        // Illegal code in RUN changes nothing
        send_cmd(3'd7);
        chk3 ("ill_run_state",  o_state, 3'd3);
        chk1 ("ill_run_enable", o_enable, 1'b1);
        chk32("ill_run_ccnt",   o_cycle_count, 32'd5);

        // ABORT during RUN
        send_cmd(3'd4);
        chk1 ("abort_enable", o_enable, 1'b0);
        chk3 ("abort_state",  o_state, 3'd0);
        chk32("abort_ccnt",   o_cycle_count, 32'd5);
        tick();
        chk32("abort_ccnt_hold", o_cycle_count, 32'd5);

        // RUN and illegal code in IDLE are ignored
        send_cmd(3'd2);
        chk3("idle_run_state",  o_state, 3'd0);
        chk1("idle_run_start",  o_start, 1'b0);
        chk1("idle_run_enable", o_enable, 1'b0);
        send_cmd(3'd7);
        chk3("idle_ill_state", o_state, 3'd0);

        // Memory full on the 4th byte of DEADBEEF
        send_cmd(3'd1);
        chk32("ovf_lcnt_clr", o_load_count, 32'd0);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        i_full_mem = 1'b1;
        send_byte(8'hEF);
        i_full_mem = 1'b0;
        chk1 ("ovf_write", o_write_mem, 1'b0);
        chk1 ("ovf_error", o_error, 1'b1);
        chk3 ("ovf_state", o_state, 3'd0);
        chk32("ovf_lcnt",  o_load_count, 32'd0);
        send_cmd(3'd1);
        chk1("ovf_err_clr", o_error, 1'b0);
        chk3("ovf_reload",  o_state, 3'd1);

        // STEP together with end of program: DONE wins, no step
        repeat (4) send_byte(8'hFF);
        chk3("pre_step_state", o_state, 3'd2);
        send_cmd(3'd3);
        chk32("st1_ccnt", o_cycle_count, 32'd1);
        tick();
        i_end_program = 1'b1;
        send_cmd(3'd3);
        i_end_program = 1'b0;
        chk3 ("step_end_state",  o_state, 3'd5);
        chk1 ("step_end_enable", o_enable, 1'b0);
        chk32("step_end_ccnt",   o_cycle_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
